// File: rtl/pdm_pkg.sv
// Shared types and helpers for the PDM capture block.
// No logic; width derivation and FSM encoding only.
package pdm_pkg;

    localparam int IDX_W = 15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Ones-count of DECIM bits ranges 0..DECIM inclusive.
    function automatic int acc_width(input int decim);
        return clog2(decim + 1);
    endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// PDM clock divider: pdm_clk high for the first half of each CLK_DIV period, strobe on the last cycle.
// Latency: strobe CLK_DIV-1 cycles after run starts; no backpressure, free-running while run is held.
module pdm_clk_gen
    import pdm_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run_q,
    input  logic run_d,
    output logic pdm_clk,
    output logic strobe
);

    localparam int DIV_W = clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pdm_clk_q, pdm_clk_d;

    // The divider only advances across consecutive RUN cycles, so a fresh run always starts at 0.
    always_comb begin
        div_d = '0;
        if (run_d && run_q) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
        pdm_clk_d = run_d && (div_d < DIV_HALF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            pdm_clk_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            pdm_clk_q <= pdm_clk_d;
        end
    end

    assign pdm_clk = pdm_clk_q;
    assign strobe  = run_q && (div_q == DIV_LAST);

endmodule

// File: rtl/pdm_capture.sv
// PDM capture: drives indx/pdm_clk, ones-counts DECIM bits per channel into PCM words. PDM_CAPTURE_FRAME_CNT_EN adds frame_cnt.
// Latency: result valid 1 cycle after the frame's last strobe; no backpressure, unaccepted results are overwritten (overrun).
module pdm_capture
    import pdm_pkg::*;
#(
    parameter int  CHANNELS  = 8,
    parameter int  NLINEFILE = 32768,
    parameter int  CLK_DIV   = 4,
    parameter int  DECIM     = 64,
    localparam int ACC_W     = acc_width(DECIM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    output logic                      pdm_clk,
    output logic [IDX_W-1:0]          indx,
    input  logic [CHANNELS-1:0]       pdm_data,
    output logic [CHANNELS*ACC_W-1:0] pcm_data,
    output logic                      pcm_valid,
    input  logic                      pcm_ready,
    output logic                      wrap,
`ifdef PDM_CAPTURE_FRAME_CNT_EN
    output logic [15:0]               frame_cnt,
`endif
    output logic                      overrun
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NLINEFILE - 1);
    localparam logic [ACC_W-1:0] BIT_LAST = ACC_W'(DECIM - 1);

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          indx_q, indx_d;
    logic                      wrap_q, wrap_d;
    logic [ACC_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [CHANNELS*ACC_W-1:0] pcm_data_q, pcm_data_d;
    logic                      pcm_valid_q, pcm_valid_d;
    logic                      overrun_q, overrun_d;
    logic [CHANNELS*ACC_W-1:0] sum_all;
    logic                      run_q, run_d, strobe, last_bit;

    assign state_d  = enable ? ST_RUN : ST_IDLE;
    assign run_q    = (state_q == ST_RUN);
    assign run_d    = (state_d == ST_RUN);
    assign last_bit = strobe && (bit_cnt_q == BIT_LAST);

    pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .run_q   (run_q),
        .run_d   (run_d),
        .pdm_clk (pdm_clk),
        .strobe  (strobe)
    );

    for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
        logic [ACC_W-1:0] acc_q, acc_d;

        assign sum_all[n*ACC_W +: ACC_W] = acc_q + ACC_W'(pdm_data[n]);

        always_comb begin
            acc_d = acc_q;
            if (!run_d || last_bit) begin
                acc_d = '0;
            end else if (strobe) begin
                acc_d = sum_all[n*ACC_W +: ACC_W];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) acc_q <= '0;
            else     acc_q <= acc_d;
        end
    end

    always_comb begin
        indx_d      = indx_q;
        wrap_d      = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        pcm_data_d  = pcm_data_q;
        pcm_valid_d = pcm_valid_q && !pcm_ready;
        overrun_d   = overrun_q;
        if (strobe) begin
            wrap_d = (indx_q == IDX_LAST);
            indx_d = (indx_q == IDX_LAST) ? '0 : indx_q + IDX_W'(1);
        end
        if (!run_d) begin
            bit_cnt_d = '0;
        end else if (strobe) begin
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + ACC_W'(1);
        end
        // A result landing on an unaccepted one replaces it; same-cycle accept is not an overrun.
        if (last_bit) begin
            pcm_data_d  = sum_all;
            pcm_valid_d = 1'b1;
            if (pcm_valid_q && !pcm_ready) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            indx_q      <= '0;
            wrap_q      <= 1'b0;
            bit_cnt_q   <= '0;
            pcm_data_q  <= '0;
            pcm_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            indx_q      <= indx_d;
            wrap_q      <= wrap_d;
            bit_cnt_q   <= bit_cnt_d;
            pcm_data_q  <= pcm_data_d;
            pcm_valid_q <= pcm_valid_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef PDM_CAPTURE_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    assign frame_cnt_d = frame_cnt_q + 16'((pcm_valid_q && pcm_ready) ? 1 : 0);

    always_ff @(posedge clk) begin
        if (rst) frame_cnt_q <= '0;
        else     frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign indx      = indx_q;
    assign wrap      = wrap_q;
    assign pcm_data  = pcm_data_q;
    assign pcm_valid = pcm_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_pdm_capture.sv
// Bench for pdm_capture: scoreboard of expected PCM frames, plus a short-index instance for wrap.
module tb_pdm_capture;

    localparam int CH  = 8;
    localparam int DIV = 4;
    localparam int DEC = 8;
    localparam int AW  = 4;

    typedef logic [CH*AW-1:0] lanes_t;

    logic           clk = 1'b0;
    logic           rst, enable, pcm_ready;
    logic           pdm_clk, pcm_valid, wrap, overrun;
    logic [14:0]    indx;
    logic [CH-1:0]  pdm_data;
    lanes_t         pcm_data;

    logic           pdm_clk2, pcm_valid2, wrap2, overrun2;
    logic [14:0]    indx2;
    logic [CH-1:0]  pdm_data2;
    lanes_t         pcm_data2;
    logic           one;
`ifdef PDM_CAPTURE_FRAME_CNT_EN
    logic [15:0]    frame_cnt, frame_cnt2;
`endif

    int     mode = 0;
    int     errors = 0;
    int     checks = 0;
    int     xfers = 0;
    lanes_t exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [CH-1:0] src(input int m, input int idx);
        logic [31:0] v;
        v = idx;
        case (m)
            0:       return '1;
            1:       return {5'b0, v[0], 1'b0, 1'b1};
            default: return v[10:3];
        endcase
    endfunction

    function automatic lanes_t frame_expect(input int m, input int start);
        lanes_t        r;
        logic [CH-1:0] b;
        r = '0;
        for (int k = 0; k < DEC; k++) begin
            b = src(m, (start + k) % 32768);
            for (int c = 0; c < CH; c++) r[c*AW +: AW] = r[c*AW +: AW] + AW'(b[c]);
        end
        return r;
    endfunction

    always_comb pdm_data = src(mode, int'(indx));
    assign pdm_data2 = '1;
    assign one       = 1'b1;

    pdm_capture #(.CHANNELS(CH), .NLINEFILE(32768), .CLK_DIV(DIV), .DECIM(DEC)) dut (
        .clk(clk), .rst(rst), .enable(enable), .pdm_clk(pdm_clk), .indx(indx),
        .pdm_data(pdm_data), .pcm_data(pcm_data), .pcm_valid(pcm_valid),
        .pcm_ready(pcm_ready), .wrap(wrap),
`ifdef PDM_CAPTURE_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .overrun(overrun)
    );

    pdm_capture #(.CHANNELS(CH), .NLINEFILE(10), .CLK_DIV(DIV), .DECIM(DEC)) dut_wrap (
        .clk(clk), .rst(rst), .enable(enable), .pdm_clk(pdm_clk2), .indx(indx2),
        .pdm_data(pdm_data2), .pcm_data(pcm_data2), .pcm_valid(pcm_valid2),
        .pcm_ready(one), .wrap(wrap2),
`ifdef PDM_CAPTURE_FRAME_CNT_EN
        .frame_cnt(frame_cnt2),
`endif
        .overrun(overrun2)
    );

    // Scoreboard: every accepted transfer must match the oldest pushed expectation.
    always @(negedge clk) begin
        lanes_t e;
        if (pcm_valid && pcm_ready && !rst) begin
            checks++;
            xfers++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected got=%h expected=none", pcm_data);
            end else begin
                e = exp_q.pop_front();
                if (pcm_data !== e) begin
                    errors++;
                    $display("FAIL scoreboard_data got=%h expected=%h", pcm_data, e);
                end
            end
        end
    end

    task automatic run_until_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!pcm_valid && n < 200);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; pcm_ready = 1'b1; mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (pdm_clk !== 1'b0)  begin errors++; $display("FAIL reset_pdm_clk got=%b expected=0", pdm_clk); end
        checks++; if (indx !== 15'd0)    begin errors++; $display("FAIL reset_indx got=%0d expected=0", indx); end
        checks++; if (pcm_data !== '0)   begin errors++; $display("FAIL reset_pcm_data got=%h expected=0", pcm_data); end
        checks++; if (pcm_valid !== 1'b0) begin errors++; $display("FAIL reset_pcm_valid got=%b expected=0", pcm_valid); end
        checks++; if (wrap !== 1'b0)     begin errors++; $display("FAIL reset_wrap got=%b expected=0", wrap); end
        checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL reset_overrun got=%b expected=0", overrun); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_all_ones();
        int n;
        mode = 0;
        exp_q.push_back(frame_expect(0, 0));
        @(posedge clk); #1 enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (pdm_clk !== (((k - 1) % DIV) < DIV / 2)) begin
                errors++; $display("FAIL pdm_clk_phase%0d got=%b", k, pdm_clk);
            end
        end
        run_until_valid(n);
        n += 4;
        checks++; if (n != 33)        begin errors++; $display("FAIL first_valid_latency got=%0d expected=33", n); end
        checks++; if (indx !== 15'd8) begin errors++; $display("FAIL first_valid_indx got=%0d expected=8", indx); end
        @(posedge clk); #1 enable = 1'b0;
    endtask

    task automatic test_pattern();
        int target, cyc;
        mode = 1;
        target = xfers + 2;
        exp_q.push_back(frame_expect(1, 8));
        exp_q.push_back(frame_expect(1, 16));
        @(posedge clk); #1 enable = 1'b1;
        cyc = 0;
        while (xfers < target && cyc < 300) begin
            @(posedge clk); @(negedge clk); cyc++;
        end
        @(posedge clk); #1 enable = 1'b0;
        checks++; if (xfers != target) begin errors++; $display("FAIL pattern_transfers got=%0d expected=%0d", xfers, target); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL pattern_overrun got=%b expected=0", overrun); end
    endtask

    task automatic test_overrun();
        int     n, cyc;
        lanes_t first;
        mode = 2;
        pcm_ready = 1'b0;
        exp_q.push_back(frame_expect(2, 32));
        @(posedge clk); #1 enable = 1'b1;
        run_until_valid(n);
        first = pcm_data;
        checks++; if (first !== frame_expect(2, 24)) begin errors++; $display("FAIL overrun_first_frame got=%h expected=%h", first, frame_expect(2, 24)); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_early got=%b expected=0", overrun); end
        repeat (3) begin @(posedge clk); @(negedge clk); end
        checks++; if (pcm_data !== first || pcm_valid !== 1'b1) begin errors++; $display("FAIL hold_stable got=%h expected=%h", pcm_data, first); end
        cyc = 0;
        while (overrun !== 1'b1 && cyc < 100) begin
            @(posedge clk); @(negedge clk); cyc++;
        end
        checks++; if (overrun !== 1'b1)  begin errors++; $display("FAIL overrun_set got=%b expected=1", overrun); end
        checks++; if (pcm_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid got=%b expected=1", pcm_valid); end
        checks++; if (pcm_data !== frame_expect(2, 32)) begin errors++; $display("FAIL overrun_newest got=%h expected=%h", pcm_data, frame_expect(2, 32)); end
        @(posedge clk); #1 enable = 1'b0; pcm_ready = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        checks++; if (pcm_valid !== 1'b0) begin errors++; $display("FAIL valid_drop got=%b expected=0", pcm_valid); end
        checks++; if (overrun !== 1'b1)   begin errors++; $display("FAIL overrun_sticky got=%b expected=1", overrun); end
    endtask

    task automatic test_reset_mid();
        int n;
        mode = 0;
        @(posedge clk); #1 enable = 1'b1;
        repeat (13) @(posedge clk);
        #1 rst = 1'b1; enable = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({pdm_clk, indx, pcm_data, pcm_valid, wrap, overrun} !== '0) begin
            errors++; $display("FAIL reset_mid_outputs got=%b/%0d/%h/%b/%b/%b expected=all0",
                               pdm_clk, indx, pcm_data, pcm_valid, wrap, overrun);
        end
        @(posedge clk); #1 rst = 1'b0;
        exp_q.push_back(frame_expect(0, 0));
        @(posedge clk); #1 enable = 1'b1;
        run_until_valid(n);
        checks++; if (n != 33)        begin errors++; $display("FAIL reset_mid_latency got=%0d expected=33", n); end
        checks++; if (indx !== 15'd8) begin errors++; $display("FAIL reset_mid_indx got=%0d expected=8", indx); end
        @(posedge clk); #1 enable = 1'b0;
    endtask

    task automatic test_pause();
        int n, clk_high;
        mode = 0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 enable = 1'b1;
        repeat (21) @(posedge clk);
        #1 enable = 1'b0;
        clk_high = 0;
        repeat (8) begin
            @(posedge clk); @(negedge clk);
            if (pdm_clk !== 1'b0) clk_high++;
        end
        checks++; if (clk_high != 0)     begin errors++; $display("FAIL idle_pdm_clk got=%0d expected=0", clk_high); end
        checks++; if (indx !== 15'd5)    begin errors++; $display("FAIL pause_indx got=%0d expected=5", indx); end
        checks++; if (pcm_valid !== 1'b0) begin errors++; $display("FAIL pause_valid got=%b expected=0", pcm_valid); end
        exp_q.push_back(frame_expect(0, 5));
        @(posedge clk); #1 enable = 1'b1;
        run_until_valid(n);
        checks++; if (n != 33)         begin errors++; $display("FAIL resume_latency got=%0d expected=33", n); end
        checks++; if (indx !== 15'd13) begin errors++; $display("FAIL resume_indx got=%0d expected=13", indx); end
        @(posedge clk); #1 enable = 1'b0;
    endtask

    task automatic test_wrap();
        int s, exp_i;
        logic exp_w;
        pcm_ready = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; enable = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk); @(negedge clk);
            s     = (n - 1) / DIV;
            exp_i = s % 10;
            exp_w = (s > 0) && ((n - 1) % DIV == 0) && (s % 10 == 0);
            checks++; if (indx2 !== 15'(exp_i)) begin errors++; $display("FAIL wrap_indx cyc%0d got=%0d expected=%0d", n, indx2, exp_i); end
            checks++; if (wrap2 !== exp_w)      begin errors++; $display("FAIL wrap_pulse cyc%0d got=%b expected=%b", n, wrap2, exp_w); end
        end
        #1 enable = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; pcm_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_pattern();
        test_overrun();
        test_reset_mid();
        test_pause();
        test_wrap();
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
